// File: rtl/frame_burst_sched_if.sv
// AXI HP0 address/response handshake bundle seen by the frame burst scheduler.
// The master modport is the scheduler; the slave modport is the interconnect/data path side.
interface frame_burst_sched_if;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_bvalid;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        m_axi_rlast;

    modport master (
        output m_axi_awvalid, m_axi_awaddr, m_axi_arvalid, m_axi_araddr,
        input  m_axi_awready, m_axi_arready, m_axi_bvalid,
        input  m_axi_rvalid, m_axi_rready, m_axi_rlast
    );

    modport slave (
        input  m_axi_awvalid, m_axi_awaddr, m_axi_arvalid, m_axi_araddr,
        output m_axi_awready, m_axi_arready, m_axi_bvalid,
        output m_axi_rvalid, m_axi_rready, m_axi_rlast
    );
endinterface

// File: rtl/frame_burst_sched.sv
// Arbitrates one AXI master between frame-capture writes and playback reads, double-buffered per vsync.
// Optional FRAME_BURST_SCHED_STATS_EN adds drop_cnt_o / stall_max_o statistics outputs.
//
// state | meaning
// IDLE  | choose next burst (read unless write starved), register its address
// AW    | write address valid, held until awready
// AR    | read address valid, held until arready
module frame_burst_sched #(
    parameter int unsigned H_WIDTH      = 1920,
    parameter int unsigned V_HEIGHT     = 1080,
    parameter int unsigned BURST_LEN    = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
    parameter int unsigned MAX_OUTST    = 4,
    parameter int unsigned WR_STARVE    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       vs_i,
    input  logic                       wr_req_i,
    output logic                       wr_gnt_o,
    input  logic                       rd_req_i,
    output logic                       rd_gnt_o,
    frame_burst_sched_if.master        axi,
    output logic                       wr_buf_o,
    output logic                       rd_buf_o
`ifdef FRAME_BURST_SCHED_STATS_EN
    ,
    output logic [15:0]                drop_cnt_o,
    output logic [15:0]                stall_max_o
`endif
);
    localparam int unsigned FRAME_BYTES = 4 * H_WIDTH * V_HEIGHT;
    localparam int unsigned BURST_BYTES = 8 * BURST_LEN;
    localparam int unsigned NB          = FRAME_BYTES / BURST_BYTES;
    localparam int unsigned CW          = $clog2(NB + 1);
    localparam int unsigned SW          = (WR_STARVE < 1) ? 1 : $clog2(WR_STARVE + 1);
    localparam logic [CW-1:0] NB_C      = CW'(NB);
    localparam logic [2:0]    MAXO_C    = 3'(MAX_OUTST);
    localparam logic [SW-1:0] WS_C      = SW'(WR_STARVE);
    localparam logic [31:0]   BBYTES_C  = 32'(BURST_BYTES);

    if (((FRAME_BYTES % BURST_BYTES) != 0) || (NB == 0)) begin : g_bad_burst
        $error("frame_burst_sched: frame is not a whole number of bursts");
    end
    if (FRAME_STRIDE < 32'(FRAME_BYTES)) begin : g_bad_stride
        $error("frame_burst_sched: FRAME_STRIDE smaller than one frame");
    end
    if ((MAX_OUTST < 1) || (MAX_OUTST > 7)) begin : g_bad_outst
        $error("frame_burst_sched: MAX_OUTST must be 1..7");
    end

    typedef enum logic [1:0] {S_IDLE, S_AW, S_AR} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [2:0]    wr_out_q, wr_out_d, rd_out_q, rd_out_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic          vs_q, vs_d;
    logic          stale_q, stale_d;
    logic [31:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;

    logic vs_edge, we, re, aw_hs, ar_hs, b_dec, r_dec;

    function automatic logic [31:0] burst_addr(input logic sel, input logic [CW-1:0] cnt);
        burst_addr = BASE_ADDR + (sel ? FRAME_STRIDE : 32'd0) + 32'(cnt) * BBYTES_C;
    endfunction

    assign vs_edge = vs_i & ~vs_q;
    assign we      = wr_req_i && (wr_cnt_q < NB_C) && (wr_out_q < MAXO_C);
    assign re      = rd_req_i && (rd_cnt_q < NB_C) && (rd_out_q < MAXO_C);
    assign aw_hs   = (state_q == S_AW) && axi.m_axi_awready;
    assign ar_hs   = (state_q == S_AR) && axi.m_axi_arready;
    assign b_dec   = axi.m_axi_bvalid && (wr_out_q != 3'd0);
    assign r_dec   = axi.m_axi_rvalid && axi.m_axi_rready && axi.m_axi_rlast && (rd_out_q != 3'd0);

    assign wr_gnt_o          = aw_hs;
    assign rd_gnt_o          = ar_hs;
    assign axi.m_axi_awvalid = (state_q == S_AW);
    assign axi.m_axi_arvalid = (state_q == S_AR);
    assign axi.m_axi_awaddr  = awaddr_q;
    assign axi.m_axi_araddr  = araddr_q;
    assign wr_buf_o          = wr_buf_q;
    assign rd_buf_o          = rd_buf_q;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        starve_d = starve_q;
        wr_buf_d = wr_buf_q;
        rd_buf_d = rd_buf_q;
        stale_d  = stale_q;
        awaddr_d = awaddr_q;
        araddr_d = araddr_q;
        vs_d     = vs_i;
        wr_out_d = wr_out_q + 3'(aw_hs) - 3'(b_dec);
        rd_out_d = rd_out_q + 3'(ar_hs) - 3'(r_dec);

        case (state_q)
            S_IDLE: begin
                // no new decision on a vsync edge: its address would belong to the old frame
                if (!vs_edge) begin
                    if (re && (!we || (starve_q < WS_C))) begin
                        state_d  = S_AR;
                        araddr_d = burst_addr(rd_buf_q, rd_cnt_q);
                    end else if (we) begin
                        state_d  = S_AW;
                        awaddr_d = burst_addr(wr_buf_q, wr_cnt_q);
                    end
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    state_d  = S_IDLE;
                    stale_d  = 1'b0;
                    starve_d = '0;
                    if (!stale_q) wr_cnt_d = wr_cnt_q + CW'(1);
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_d = S_IDLE;
                    stale_d = 1'b0;
                    if (!stale_q) begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                        if (we && (starve_q < WS_C)) starve_d = starve_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // frame boundary overrides any counter update of this cycle
        if (vs_edge) begin
            if (wr_cnt_q == NB_C) begin
                rd_buf_d = wr_buf_q;
                wr_buf_d = ~wr_buf_q;
            end
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            starve_d = '0;
            stale_d  = (state_q != S_IDLE) && !aw_hs && !ar_hs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_out_q <= '0;
            rd_out_q <= '0;
            starve_q <= '0;
            wr_buf_q <= 1'b0;
            rd_buf_q <= 1'b1;
            vs_q     <= 1'b0;
            stale_q  <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
            starve_q <= starve_d;
            wr_buf_q <= wr_buf_d;
            rd_buf_q <= rd_buf_d;
            vs_q     <= vs_d;
            stale_q  <= stale_d;
            awaddr_q <= awaddr_d;
            araddr_q <= araddr_d;
        end
    end

`ifdef FRAME_BURST_SCHED_STATS_EN
    logic [15:0] drop_q, drop_d, run_q, run_d, smax_q, smax_d;
    logic        stalled;

    assign stalled     = ((state_q == S_AW) && !axi.m_axi_awready) ||
                         ((state_q == S_AR) && !axi.m_axi_arready);
    assign drop_cnt_o  = drop_q;
    assign stall_max_o = smax_q;

    always_comb begin
        drop_d = drop_q;
        run_d  = '0;
        if (vs_edge && (wr_cnt_q != NB_C) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (stalled) run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        smax_d = (run_d > smax_q) ? run_d : smax_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
            run_q  <= '0;
            smax_q <= '0;
        end else begin
            drop_q <= drop_d;
            run_q  <= run_d;
            smax_q <= smax_d;
        end
    end
`endif
endmodule

// File: tb/tb_frame_burst_sched.sv
// Bench for frame_burst_sched: randomized-free directed scenarios plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_frame_burst_sched;
    localparam int H    = 64;
    localparam int V    = 2;
    localparam int BL   = 16;
    localparam int MAXO = 4;
    localparam int WS   = 2;
    localparam int NB   = 4 * H * V / (8 * BL);
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0080_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic wr_gnt, rd_gnt, wr_buf, rd_buf;
`ifdef FRAME_BURST_SCHED_STATS_EN
    logic [15:0] drop_cnt, stall_max;
`endif

    frame_burst_sched_if bus();

    frame_burst_sched #(
        .H_WIDTH(H), .V_HEIGHT(V), .BURST_LEN(BL), .BASE_ADDR(BASE),
        .FRAME_STRIDE(STRIDE), .MAX_OUTST(MAXO), .WR_STARVE(WS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .vs_i(vs),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt),
        .axi(bus.master),
        .wr_buf_o(wr_buf), .rd_buf_o(rd_buf)
`ifdef FRAME_BURST_SCHED_STATS_EN
        , .drop_cnt_o(drop_cnt), .stall_max_o(stall_max)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- reference model: frame bookkeeping + one pending request
    int          m_wcnt = 0, m_rcnt = 0, m_wout = 0, m_rout = 0, m_starve = 0;
    int          m_wbuf = 0, m_rbuf = 1;
    int          m_pend = 0;           // 0 none, 1 write address pending, 2 read address pending
    bit          m_stale = 0, m_vs = 0;
    logic [31:0] m_awaddr = '0, m_araddr = '0;
    bit          e_edge, e_we, e_re, e_aw, e_ar, e_idle;
    int          e_wold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wcnt = 0; m_rcnt = 0; m_wout = 0; m_rout = 0; m_starve = 0;
            m_wbuf = 0; m_rbuf = 1; m_pend = 0; m_stale = 0; m_vs = 0;
            m_awaddr = '0; m_araddr = '0;
        end else begin
            e_edge = vs && !m_vs;
            m_vs   = vs;
            e_we   = wr_req && (m_wcnt < NB) && (m_wout < MAXO);
            e_re   = rd_req && (m_rcnt < NB) && (m_rout < MAXO);
            e_aw   = (m_pend == 1) && bus.m_axi_awready;
            e_ar   = (m_pend == 2) && bus.m_axi_arready;
            e_idle = (m_pend == 0);
            e_wold = m_wcnt;
            if (bus.m_axi_bvalid && m_wout > 0) m_wout--;
            if (e_aw) m_wout++;
            if (bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast && m_rout > 0) m_rout--;
            if (e_ar) m_rout++;
            if (e_aw) begin
                if (!m_stale) m_wcnt++;
                m_starve = 0; m_pend = 0; m_stale = 0;
            end
            if (e_ar) begin
                if (!m_stale) begin
                    m_rcnt++;
                    if (e_we) m_starve = (m_starve + 1 > WS) ? WS : m_starve + 1;
                end
                m_pend = 0; m_stale = 0;
            end
            if (e_edge) begin
                if (e_wold == NB) begin m_rbuf = m_wbuf; m_wbuf = 1 - m_wbuf; end
                m_wcnt = 0; m_rcnt = 0; m_starve = 0;
                if (m_pend != 0) m_stale = 1;
            end else if (e_idle) begin
                if (e_re && (!e_we || m_starve < WS)) begin
                    m_pend = 2; m_araddr = BASE + m_rbuf * STRIDE + m_rcnt * BL * 8;
                end else if (e_we) begin
                    m_pend = 1; m_awaddr = BASE + m_wbuf * STRIDE + m_wcnt * BL * 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("awvalid", bus.m_axi_awvalid, m_pend == 1);
        check("arvalid", bus.m_axi_arvalid, m_pend == 2);
        check("wr_gnt", wr_gnt, (m_pend == 1) && bus.m_axi_awready);
        check("rd_gnt", rd_gnt, (m_pend == 2) && bus.m_axi_arready);
        check("wr_buf", wr_buf, m_wbuf[0]);
        check("rd_buf", rd_buf, m_rbuf[0]);
        if (m_pend == 1) check("awaddr", bus.m_axi_awaddr, m_awaddr);
        if (m_pend == 2) check("araddr", bus.m_axi_araddr, m_araddr);
    end

    // ---------------- grant logs and response generators
    logic [31:0] aw_log[$], ar_log[$];
    byte         order[$];
    int          b_t[$], r_t[$];
    bit          b_auto = 0, r_auto = 0, b_man = 0;

    always @(negedge clk) begin
        if (wr_gnt) begin
            aw_log.push_back(bus.m_axi_awaddr); order.push_back("W");
            if (b_auto) b_t.push_back(3);
        end
        if (rd_gnt) begin
            ar_log.push_back(bus.m_axi_araddr); order.push_back("R");
            if (r_auto) r_t.push_back(3);
        end
    end

    initial begin
        logic bh, rh;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bh = 1'b0; rh = 1'b0;
            foreach (b_t[i]) b_t[i]--;
            foreach (r_t[i]) r_t[i]--;
            if (b_t.size() > 0 && b_t[0] <= 0) begin void'(b_t.pop_front()); bh = 1'b1; end
            if (r_t.size() > 0 && r_t[0] <= 0) begin void'(r_t.pop_front()); rh = 1'b1; end
            bus.m_axi_bvalid = bh | b_man;
            bus.m_axi_rvalid = rh;
            bus.m_axi_rlast  = rh;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input bit rd, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd ? bus.m_axi_arvalid : bus.m_axi_awvalid) break;
        end
        n_chk++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s: valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_vs();
        vs = 1'b1; cyc(1); vs = 1'b0; cyc(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_addr;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rready  = 1'b1;
        cyc(3);
        check("rst_awvalid", bus.m_axi_awvalid, 0);
        check("rst_arvalid", bus.m_axi_arvalid, 0);
        check("rst_wr_gnt", wr_gnt, 0);
        check("rst_wr_buf", wr_buf, 0);
        check("rst_rd_buf", rd_buf, 1);
        rst_n = 1'b1;
        cyc(2);

        // one full write frame, 5th request unanswered
        b_auto = 1; wr_req = 1'b1;
        cyc(20);
        check("frame_gnts", aw_log.size(), 4);
        check("aw0", aw_log[0], 32'h1000_0000);
        check("aw1", aw_log[1], 32'h1000_0080);
        check("aw2", aw_log[2], 32'h1000_0100);
        check("aw3", aw_log[3], 32'h1000_0180);
        check("no_5th", bus.m_axi_awvalid, 0);
        wr_req = 1'b0;

        // complete frame swaps buffers
        pulse_vs();
        check("swap_wr_buf", wr_buf, 1);
        check("swap_rd_buf", rd_buf, 0);

        // starvation bound with both requesters busy
        aw_log.delete(); ar_log.delete(); order.delete();
        r_auto = 1; wr_req = 1'b1; rd_req = 1'b1;
        cyc(30);
        check("order_len", order.size(), 8);
        for (int i = 0; i < 6; i++) begin
            byte want_o[6];
            want_o = '{"R", "R", "W", "R", "R", "W"};
            check($sformatf("order%0d", i), order[i], want_o[i]);
        end
        check("aw_after_swap", aw_log[0], 32'h1080_0000);
        check("ar_after_swap", ar_log[0], 32'h1000_0000);
        check("ar_second", ar_log[1], 32'h1000_0080);
        wr_req = 1'b0; rd_req = 1'b0;

        // outstanding write limit
        pulse_vs();
        cyc(10);
        b_auto = 0; aw_log.delete();
        wr_req = 1'b1;
        cyc(20);
        check("outst_gnts", aw_log.size(), 4);
        pulse_vs();
        cyc(15);
        check("outst_blocked", aw_log.size(), 4);
        b_man = 1; cyc(1); b_man = 0;
        cyc(10);
        check("outst_one_more", aw_log.size(), 5);
        check("outst_addr", aw_log[4], 32'h1080_0000);
        wr_req = 1'b0;
        cyc(2);
        repeat (4) begin b_man = 1; cyc(1); b_man = 0; cyc(1); end

        // address held across a stalled write and an incomplete-frame vsync
        b_auto = 1; bus.m_axi_awready = 1'b0; wr_req = 1'b1;
        wait_valid("stall_aw", 0, 10);
        hold_addr = bus.m_axi_awaddr;
        check("stall_addr", hold_addr, 32'h1080_0080);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) vs = 1'b1;
            if (i == 4) vs = 1'b0;
            check("stall_valid", bus.m_axi_awvalid, 1);
            check("stall_hold", bus.m_axi_awaddr, hold_addr);
        end
        bus.m_axi_awready = 1'b1; wr_req = 1'b0;
        cyc(3);
        check("drop_wr_buf", wr_buf, 1);
        check("drop_rd_buf", rd_buf, 0);
        check("drop_gnts", aw_log.size(), 6);
        wr_req = 1'b1;
        wait_valid("restart_aw", 0, 10);
        check("wr_cnt_cleared", bus.m_axi_awaddr, 32'h1080_0000);
        @(posedge clk); #1;
        wr_req = 1'b0;
        cyc(6);
`ifdef FRAME_BURST_SCHED_STATS_EN
        check("drop_cnt", drop_cnt, 1);
        check("stall_max", stall_max, 10);
`endif

        // reset while a read address is pending
        bus.m_axi_arready = 1'b0; rd_req = 1'b1;
        wait_valid("rst_ar", 1, 10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", bus.m_axi_arvalid, 0);
        check("mid_rst_rd_buf", rd_buf, 1);
        check("mid_rst_wr_buf", wr_buf, 0);
        @(posedge clk); #1;
        b_t.delete(); r_t.delete();
        rst_n = 1'b1; bus.m_axi_arready = 1'b1;
        @(negedge clk);
        check("post_rst_gnt0", rd_gnt, 0);
        @(negedge clk);
        check("post_rst_gnt1", rd_gnt, 1);
        @(posedge clk); #1;
        rd_req = 1'b0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_burst_sched.md
Name: frame_burst_sched

Overview:
- Schedules the single AXI HP0 master port between the frame-capture write requester and the playback read requester inside the DDR frame delayer.
- Generates double-buffered frame burst addresses and issues AW/AR address phases.
- Enforces per-channel outstanding-transaction limits and bounds write starvation.
- Swaps the write and read frame buffers at each vertical-sync edge.

Parameters:
- H_WIDTH, 1920, active pixels per line.
- V_HEIGHT, 1080, active lines per frame.
- BURST_LEN, 16, beats per burst; each beat is 64 bits. Drives awlen/arlen = BURST_LEN-1. Burst size is 8*BURST_LEN bytes.
- BASE_ADDR, 32'h1000_0000, DDR byte address of frame buffer 0.
- FRAME_STRIDE, 32'h0080_0000, byte offset from buffer 0 to buffer 1. Must be ≥ 4*H_WIDTH*V_HEIGHT.
- MAX_OUTST, 4, maximum outstanding bursts per channel (1..7).
- WR_STARVE, 8, maximum consecutive read grants while a write is pending.

Ports:
- clk_i  in  1  pixel clock; also drives the AXI master.
- rst_ni  in  1  asynchronous active-low reset.
- vs_i  in  1  vertical sync; rising edge marks frame start.
- wr_req_i  in  1  write requester holds high while it has a burst ready.
- wr_gnt_o  out  1  one-cycle pulse when the write burst address is accepted.
- rd_req_i  in  1  read requester holds high while it has room for a burst.
- rd_gnt_o  out  1  one-cycle pulse when the read burst address is accepted.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_awaddr  out  32  write burst byte address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_araddr  out  32  read burst byte address.
- m_axi_bvalid  in  1  write response valid; m_axi_bready is tied high outside this block.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  in  1  read data ready, as driven by the data path.
- m_axi_rlast  in  1  last read beat.
- wr_buf_o  out  1  buffer index currently being written.
- rd_buf_o  out  1  buffer index currently being read.

Behaviour:
- Reset: all outputs 0. wr_buf=0, rd_buf=1. Burst counters, outstanding counters and starvation counter all 0. State IDLE.
- NB = 4*H_WIDTH*V_HEIGHT / (8*BURST_LEN), computed at elaboration. Synthesis must fail if the division is inexact.
- Address calculation:
  - awaddr = BASE_ADDR + wr_buf*FRAME_STRIDE + wr_cnt*8*BURST_LEN.
  - araddr is formed the same way from rd_buf and rd_cnt.
  - Arithmetic is 32-bit and wraps modulo 2^32.
- Write eligibility (we): wr_req_i && wr_cnt<NB && wr_out<MAX_OUTST.
- Read eligibility (re): rd_req_i && rd_cnt<NB && rd_out<MAX_OUTST.
- States: IDLE, AW, AR.
- IDLE transitions:
  - re && (!we || starve<WR_STARVE) → AR.
  - Otherwise, we → AW.
  - Decision is registered; valid asserts in the cycle after the decision.
- AW state:
  - awvalid stays high and awaddr stays stable until awready is seen.
  - On handshake: wr_gnt_o pulses, wr_cnt++, wr_out++, starve←0, return to IDLE.
- AR state:
  - arvalid stays high and araddr stays stable until arready is seen.
  - On handshake: rd_gnt_o pulses, rd_cnt++, rd_out++, return to IDLE.
  - starve increments only if we was true at the grant; it saturates at WR_STARVE.
- Outstanding counters:
  - wr_out decrements on each bvalid.
  - rd_out decrements on each rvalid&&rready&&rlast.
  - A simultaneous increment and decrement leaves the count unchanged.
  - Counters never underflow; a stray response at 0 is ignored.
- Frame swap on vs_i rising edge (detected with one register stage):
  - If wr_cnt==NB: rd_buf←wr_buf and wr_buf←~wr_buf.
  - Otherwise (frame incomplete): the write frame is discarded and buffers are unchanged.
  - In both cases wr_cnt←0, rd_cnt←0, starve←0.
  - If the edge arrives while in AW/AR, the pending address remains valid until its handshake (AXI rule). That handshake does not increment the cleared counter.
- Counters saturate at NB. Requests beyond NB receive no grant until the next frame.
- Reset mid-burst drops valids immediately. Outstanding AXI transactions are the interconnect's concern.

Optional Feature:
- Macro: FRAME_BURST_SCHED_STATS_EN.
- When defined, adds two outputs:
  - drop_cnt_o (16 bits): counts vs edges with wr_cnt<NB; saturates at 16'hFFFF.
  - stall_max_o (16 bits): longest run of awvalid or arvalid high without ready, in cycles; saturates.
  - Both reset to 0.
- When undefined, neither port nor any of its logic exists.

Test Plan:
- Bench parameters: H_WIDTH=64, V_HEIGHT=2, BURST_LEN=16 (NB=4). Hold wr_req_i high with awready=1 and bvalid returned 3 cycles after each AW → 4 wr_gnt_o pulses at awaddr 0x1000_0000, 0x80, 0x100, 0x180. A 5th request gets no grant.
- After the frame above completes, pulse vs_i → wr_buf_o=1, rd_buf_o=0. The next AW goes to 0x1080_0000 and the next AR goes to 0x1000_0000.
- Both requests held high, WR_STARVE=2, no read-side limit hit → grant order AR, AR, AW, AR, AR, AW.
- Withhold bvalid → exactly MAX_OUTST=4 AWs are issued. A single bvalid allows exactly one more AW.
- awready held low for 10 cycles while vs_i rises → awaddr stays stable and awvalid stays held. After the handshake wr_cnt=0 and buffers are unchanged because the frame was incomplete. With FRAME_BURST_SCHED_STATS_EN defined: drop_cnt_o=1, stall_max_o=10.
- Assert rst_ni low for 1 cycle during AR → arvalid=0 immediately, rd_buf_o=1, wr_buf_o=0. A grant is possible again 2 cycles after release.
